// File: rtl/fifo_rd_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_rd_ctrl
//
// Read-side controller for an asynchronous (dual-clock) FIFO. It owns the
// binary/Gray read pointer pair. It compares the read pointer against the
// write pointer, which has already been synchronized into i_clk. From that
// comparison it produces registered empty, almost-empty and occupancy flags.
//
// Parameters
//   ADDR_WIDTH     FIFO memory address width; depth = 2**ADDR_WIDTH
//   AEMPTY_THRESH  o_almost_empty asserts at occupancy <= this value
//
// Ports
//   i_clk          read-domain clock (only clock used)
//   i_rst          asynchronous active-high reset
//   i_rd_en        pop request; accepted only when o_empty is low
//   i_rq2_wptr     Gray write pointer, double-FF synchronized into i_clk
//   o_rd_addr      read address to the FIFO memory (straight from a flop)
//   o_rptr         registered Gray read pointer for the write-side syncs
//   o_empty        FIFO empty
//   o_almost_empty occupancy <= AEMPTY_THRESH (always set when empty)
//   o_rd_level     read-side occupancy, 0 .. 2**ADDR_WIDTH
//   o_rd_valid     memory read data valid, one cycle after an accepted pop
//   o_underflow    sticky read-while-empty error
//
// Configuration
//   FIFO_RD_UNDERFLOW_EN  when defined, o_underflow sets on a pop request
//                         made while empty and holds until reset. When it is
//                         undefined, o_underflow is tied to 0.
// ---------------------------------------------------------------------------
module fifo_rd_ctrl #(
  parameter int ADDR_WIDTH    = 3,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_rd_en,
  input  logic [ADDR_WIDTH:0]   i_rq2_wptr,
  output logic [ADDR_WIDTH-1:0] o_rd_addr,
  output logic [ADDR_WIDTH:0]   o_rptr,
  output logic                  o_empty,
  output logic                  o_almost_empty,
  output logic [ADDR_WIDTH:0]   o_rd_level,
  output logic                  o_rd_valid,
  output logic                  o_underflow
);

  localparam int PW = ADDR_WIDTH + 1;

  // Threshold in pointer width, so the comparison is a plain unsigned one.
  localparam logic [ADDR_WIDTH:0] AEMPTY_LIM = PW'(AEMPTY_THRESH);

  // -------------------------------------------------------------------------
  // Gray <-> binary helpers
  // -------------------------------------------------------------------------
  function automatic logic [ADDR_WIDTH:0] bin2gray(input logic [ADDR_WIDTH:0] b);
    return (b >> 1) ^ b;
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [ADDR_WIDTH:0] gray2bin(input logic [ADDR_WIDTH:0] g);
    logic [ADDR_WIDTH:0] b;
    b             = '0;
    b[ADDR_WIDTH] = g[ADDR_WIDTH];
    for (int i = ADDR_WIDTH - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [ADDR_WIDTH:0] rbin_q,   rbin_d;
  logic [ADDR_WIDTH:0] rptr_q,   rptr_d;
  logic [ADDR_WIDTH:0] level_q,  level_d;
  logic                empty_q,  empty_d;
  logic                aempty_q, aempty_d;
  logic                rd_valid_q, rd_valid_d;
  logic                underflow_q, underflow_d;

  logic                rd_accept;
  logic [ADDR_WIDTH:0] wbin;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before any conditional logic.
    // A path that leaves a signal unassigned in always_comb infers a latch.
    rd_accept  = 1'b0;
    rbin_d     = rbin_q;
    rptr_d     = rptr_q;
    wbin       = '0;
    level_d    = level_q;
    empty_d    = empty_q;
    aempty_d   = aempty_q;
    rd_valid_d = 1'b0;

    // A pop counts only against the registered empty flag, so a pop can
    // never run the read pointer past the synchronized write pointer.
    rd_accept = i_rd_en & ~empty_q;

    rbin_d = rbin_q + {{ADDR_WIDTH{1'b0}}, rd_accept};
    rptr_d = bin2gray(rbin_d);

    // All flags are computed from the post-pop pointer. This lets the block's
    // own pop show up in the flags on the very next cycle. A write-pointer
    // change in the same cycle is reflected on that same cycle too.
    // The synchronized write pointer can only lag the real one. A lag makes
    // the occupancy look smaller, so empty may be late to deassert. It can
    // never deassert early.
    wbin    = gray2bin(i_rq2_wptr);
    level_d = wbin - rbin_d;  // modulo 2**PW; MSB difference gives full depth
    empty_d = (rptr_d == i_rq2_wptr);

    // The empty term keeps the "almost empty covers empty" guarantee
    // even for a threshold that truncates in pointer width.
    aempty_d = empty_d | (level_d <= AEMPTY_LIM);

    // Data for the address presented this cycle appears after the next
    // edge from a registered memory read.
    rd_valid_d = rd_accept;
  end

`ifdef FIFO_RD_UNDERFLOW_EN
  // Sticky: once a pop is requested while empty, hold until reset.
  assign underflow_d = underflow_q | (i_rd_en & empty_q);
`else
  assign underflow_d = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments. All flops then
  // sample their inputs together on the edge, independent of statement order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rbin_q      <= '0;
      rptr_q      <= '0;
      level_q     <= '0;
      empty_q     <= 1'b1;
      aempty_q    <= 1'b1;
      rd_valid_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      rbin_q      <= rbin_d;
      rptr_q      <= rptr_d;
      level_q     <= level_d;
      empty_q     <= empty_d;
      aempty_q    <= aempty_d;
      rd_valid_q  <= rd_valid_d;
      underflow_q <= underflow_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs: all come straight from flops with no logic after them
  // -------------------------------------------------------------------------
  assign o_rd_addr      = rbin_q[ADDR_WIDTH-1:0];
  assign o_rptr         = rptr_q;
  assign o_empty        = empty_q;
  assign o_almost_empty = aempty_q;
  assign o_rd_level     = level_q;
  assign o_rd_valid     = rd_valid_q;
  assign o_underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fifo_rd_ctrl
//
// Directed bench for fifo_rd_ctrl with ADDR_WIDTH=3 and AEMPTY_THRESH=2.
// It covers reset values, draining, read-while-empty, full occupancy,
// pointer wrap, and reset asserted during a read burst. Expected values are
// worked out by hand. The wrap section uses a small pointer model.
// Inputs change 1 time unit after the rising edge, and outputs are
// checked at that same point.
// ---------------------------------------------------------------------------
module tb_fifo_rd_ctrl;

  logic       clk = 1'b0;
  logic       i_rst = 1'b0;
  logic       i_rd_en = 1'b0;
  logic [3:0] i_rq2_wptr = 4'b0000;
  logic [2:0] o_rd_addr;
  logic [3:0] o_rptr;
  logic       o_empty;
  logic       o_almost_empty;
  logic [3:0] o_rd_level;
  logic       o_rd_valid;
  logic       o_underflow;

  int checks = 0;
  int errors = 0;

`ifdef FIFO_RD_UNDERFLOW_EN
  localparam logic UF_EXP = 1'b1;
`else
  localparam logic UF_EXP = 1'b0;
`endif

  fifo_rd_ctrl #(
    .ADDR_WIDTH    (3),
    .AEMPTY_THRESH (2)
  ) dut (
    .i_clk          (clk),
    .i_rst          (i_rst),
    .i_rd_en        (i_rd_en),
    .i_rq2_wptr     (i_rq2_wptr),
    .o_rd_addr      (o_rd_addr),
    .o_rptr         (o_rptr),
    .o_empty        (o_empty),
    .o_almost_empty (o_almost_empty),
    .o_rd_level     (o_rd_level),
    .o_rd_valid     (o_rd_valid),
    .o_underflow    (o_underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] gray(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, "_rptr"},   32'(o_rptr),         32'h0);
    check({tag, "_addr"},   32'(o_rd_addr),      32'h0);
    check({tag, "_empty"},  32'(o_empty),        32'h1);
    check({tag, "_aempty"}, 32'(o_almost_empty), 32'h1);
    check({tag, "_level"},  32'(o_rd_level),     32'h0);
    check({tag, "_valid"},  32'(o_rd_valid),     32'h0);
    check({tag, "_uflow"},  32'(o_underflow),    32'h0);
  endtask

  // Watchdog so the run always ends on its own.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] rbin_m;
    logic [3:0] wbin_m;
    logic [3:0] lvl;

    // ---------------- Reset with write pointer at bin 3 ----------------
    i_rq2_wptr = 4'b0010;
    #2 i_rst = 1'b1;
    #2;
    check_reset_values("rst");
    next_edge();
    check("rst_hold_empty", 32'(o_empty), 32'h1);
    i_rst = 1'b0;
    next_edge();
    check("rel_empty",  32'(o_empty),        32'h0);
    check("rel_level",  32'(o_rd_level),     32'h3);
    check("rel_aempty", 32'(o_almost_empty), 32'h0);
    check("rel_valid",  32'(o_rd_valid),     32'h0);

    // ---------------- Drain three entries ----------------
    for (int i = 0; i < 3; i++) begin
      logic [3:0] exp_rptr [3];
      exp_rptr = '{4'b0001, 4'b0011, 4'b0010};
      i_rd_en = 1'b1;
      check($sformatf("drain%0d_addr", i), 32'(o_rd_addr), 32'(i));
      next_edge();
      check($sformatf("drain%0d_rptr", i),   32'(o_rptr),         32'(exp_rptr[i]));
      check($sformatf("drain%0d_level", i),  32'(o_rd_level),     32'(2 - i));
      check($sformatf("drain%0d_empty", i),  32'(o_empty),        32'(i == 2));
      check($sformatf("drain%0d_valid", i),  32'(o_rd_valid),     32'h1);
      check($sformatf("drain%0d_aempty", i), 32'(o_almost_empty), 32'h1);
    end

    // ---------------- Read while empty ----------------
    next_edge();  // i_rd_en still high, FIFO empty
    check("uflow_rptr",  32'(o_rptr),      32'b0010);
    check("uflow_addr",  32'(o_rd_addr),   32'h3);
    check("uflow_valid", 32'(o_rd_valid),  32'h0);
    check("uflow_flag",  32'(o_underflow), 32'(UF_EXP));
    i_rd_en = 1'b0;
    next_edge();
    check("uflow_sticky", 32'(o_underflow), 32'(UF_EXP));
    check("uflow_empty",  32'(o_empty),     32'h1);

    // ---------------- Full occupancy: rptr 0, wptr bin 8 ----------------
    i_rq2_wptr = 4'b1100;
    i_rst = 1'b1;
    #1;
    check("full_rst_rptr",  32'(o_rptr),      32'h0);
    check("full_rst_uflow", 32'(o_underflow), 32'h0);
    next_edge();
    i_rst = 1'b0;
    next_edge();
    check("full_level",  32'(o_rd_level),     32'h8);
    check("full_empty",  32'(o_empty),        32'h0);
    check("full_aempty", 32'(o_almost_empty), 32'h0);

    // ---------------- Wrap: 16 reads, write pointer kept ahead ----------------
    i_rq2_wptr = gray(4'd1);
    i_rst = 1'b1;
    next_edge();
    i_rst = 1'b0;
    next_edge();
    rbin_m = 4'd0;
    wbin_m = 4'd1;
    check("wrap_start_level", 32'(o_rd_level), 32'h1);
    for (int k = 0; k < 16; k++) begin
      if (k % 2 == 0) wbin_m = wbin_m + 4'd2;
      i_rq2_wptr = gray(wbin_m);
      i_rd_en    = 1'b1;
      check($sformatf("wrap%0d_addr", k), 32'(o_rd_addr), 32'(rbin_m[2:0]));
      next_edge();
      rbin_m = rbin_m + 4'd1;
      lvl    = wbin_m - rbin_m;
      check($sformatf("wrap%0d_rptr", k),   32'(o_rptr),         32'(gray(rbin_m)));
      check($sformatf("wrap%0d_level", k),  32'(o_rd_level),     32'(lvl));
      check($sformatf("wrap%0d_empty", k),  32'(o_empty),        32'(lvl == 4'd0));
      check($sformatf("wrap%0d_aempty", k), 32'(o_almost_empty), 32'(lvl <= 4'd2));
    end
    i_rd_en = 1'b0;
    next_edge();
    check("wrap_rptr_home", 32'(o_rptr),     32'h0);
    check("wrap_end_level", 32'(o_rd_level), 32'h1);

    // ---------------- Reset during a read burst ----------------
    i_rq2_wptr = gray(4'd4);
    i_rd_en    = 1'b1;
    next_edge();
    check("mid_pre_rptr",  32'(o_rptr),     32'b0001);
    check("mid_pre_level", 32'(o_rd_level), 32'h3);
    #3 i_rst = 1'b1;
    #1;
    check_reset_values("mid");
    next_edge();
    i_rq2_wptr = gray(4'd3);
    i_rst      = 1'b0;
    next_edge();
    check("mid_rel_valid", 32'(o_rd_valid), 32'h0);
    check("mid_rel_rptr",  32'(o_rptr),     32'h0);
    check("mid_rel_empty", 32'(o_empty),    32'h0);
    check("mid_rel_level", 32'(o_rd_level), 32'h3);
    next_edge();
    check("mid_resume_valid", 32'(o_rd_valid), 32'h1);
    check("mid_resume_rptr",  32'(o_rptr),     32'b0001);
    check("mid_resume_level", 32'(o_rd_level), 32'h2);
    i_rd_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
